// File: rtl/tt_waves_pkg.sv
// Shared widths, wave select codes and LFSR constants for the waveform generator.
package tt_waves_pkg;

    localparam int unsigned CntW    = 5;
    localparam int unsigned PhaseW  = 8;
    localparam int unsigned SampleW = 8;
    localparam int unsigned LfsrW   = 16;

    typedef enum logic [2:0] {
        WaveSquare = 3'b000,
        WaveSaw    = 3'b001,
        WaveTri    = 3'b010,
        WaveSine   = 3'b011,
        WaveRsaw   = 3'b100,
        WaveNoise  = 3'b101,
        WaveRsvd6  = 3'b110,
        WaveRsvd7  = 3'b111
    } wave_sel_e;

    localparam logic [LfsrW-1:0]   LfsrSeed  = 16'hACE1;
    // Taps 16,14,13,11 in right-shifting form map to bits 0,2,3,5.
    localparam logic [LfsrW-1:0]   LfsrTaps  = 16'h002D;
    localparam logic [SampleW-1:0] MidScale  = 8'h80;

    // One Fibonacci step: feedback enters at the MSB, register shifts right.
    function automatic logic [LfsrW-1:0] lfsr_next(input logic [LfsrW-1:0] state);
        logic fb;
        fb = ^(state & LfsrTaps);
        return {fb, state[LfsrW-1:1]};
    endfunction

endpackage

// File: rtl/wave_sine_lut.sv
// Quarter-wave sine table with quadrant folding; purely combinational.
module wave_sine_lut
    import tt_waves_pkg::*;
(
    input  logic [PhaseW-1:0]  phase,
    output logic [SampleW-1:0] sample
);

    logic [5:0] idx;
    logic [6:0] q;

    // Quarter-wave table: round(127*sin(2*pi*(k+0.5)/256)).
    function automatic logic [6:0] quarter(input logic [5:0] k);
        logic [6:0] v;
        unique case (k)
            6'd0:  v = 7'd2;    6'd1:  v = 7'd5;    6'd2:  v = 7'd8;    6'd3:  v = 7'd11;
            6'd4:  v = 7'd14;   6'd5:  v = 7'd17;   6'd6:  v = 7'd20;   6'd7:  v = 7'd23;
            6'd8:  v = 7'd26;   6'd9:  v = 7'd29;   6'd10: v = 7'd32;   6'd11: v = 7'd35;
            6'd12: v = 7'd38;   6'd13: v = 7'd41;   6'd14: v = 7'd44;   6'd15: v = 7'd47;
            6'd16: v = 7'd50;   6'd17: v = 7'd53;   6'd18: v = 7'd56;   6'd19: v = 7'd58;
            6'd20: v = 7'd61;   6'd21: v = 7'd64;   6'd22: v = 7'd67;   6'd23: v = 7'd69;
            6'd24: v = 7'd72;   6'd25: v = 7'd74;   6'd26: v = 7'd77;   6'd27: v = 7'd79;
            6'd28: v = 7'd82;   6'd29: v = 7'd84;   6'd30: v = 7'd86;   6'd31: v = 7'd89;
            6'd32: v = 7'd91;   6'd33: v = 7'd93;   6'd34: v = 7'd95;   6'd35: v = 7'd97;
            6'd36: v = 7'd99;   6'd37: v = 7'd101;  6'd38: v = 7'd103;  6'd39: v = 7'd105;
            6'd40: v = 7'd106;  6'd41: v = 7'd108;  6'd42: v = 7'd110;  6'd43: v = 7'd111;
            6'd44: v = 7'd113;  6'd45: v = 7'd114;  6'd46: v = 7'd115;  6'd47: v = 7'd117;
            6'd48: v = 7'd118;  6'd49: v = 7'd119;  6'd50: v = 7'd120;  6'd51: v = 7'd121;
            6'd52: v = 7'd122;  6'd53: v = 7'd123;  6'd54: v = 7'd124;  6'd55: v = 7'd124;
            6'd56: v = 7'd125;  6'd57: v = 7'd125;  6'd58: v = 7'd126;  6'd59: v = 7'd126;
            6'd60: v = 7'd127;  6'd61: v = 7'd127;  6'd62: v = 7'd127;  6'd63: v = 7'd127;
        endcase
        return v;
    endfunction

    // Odd quadrants read the table backwards (63-i == ~i); upper half mirrors below midscale.
    always_comb begin
        idx    = phase[6] ? ~phase[5:0] : phase[5:0];
        q      = quarter(idx);
        sample = phase[7] ? (8'd127 - {1'b0, q}) : (8'd128 + {1'b0, q});
    end

endmodule

// File: rtl/tt_um_waves.sv
// Waveform generator: prescaled phase accumulator feeding a registered wave-shape mux.
module tt_um_waves
    import tt_waves_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [PhaseW-1:0]  phase_q, phase_d;
    logic [LfsrW-1:0]   lfsr_q, lfsr_d;
    logic [SampleW-1:0] sample_q, sample_d;
    logic [CntW-1:0]    div;
    logic               tick;
    wave_sel_e          sel;
    logic [SampleW-1:0] sine_sample;
    logic               unused_uio;

    assign div        = ui_in[7:3];
    assign sel        = wave_sel_e'(ui_in[2:0]);
    assign unused_uio = ^uio_in;

    wave_sine_lut u_sine (
        .phase  (phase_q),
        .sample (sine_sample)
    );

    // Prescaler and phase/LFSR advance; >= lets a lowered DIV force an immediate tick.
    always_comb begin
        tick    = (cnt_q >= div);
        cnt_d   = tick ? '0 : cnt_q + 5'd1;
        phase_d = tick ? phase_q + 8'd1 : phase_q;
        lfsr_d  = tick ? lfsr_next(lfsr_q) : lfsr_q;
    end

    // Wave shape from the pre-edge phase and LFSR.
    always_comb begin
        sample_d = MidScale;
        unique case (sel)
            WaveSquare: sample_d = phase_q[7] ? 8'hFF : 8'h00;
            WaveSaw:    sample_d = phase_q;
            WaveTri:    sample_d = phase_q[7] ? ~{phase_q[6:0], 1'b0} : {phase_q[6:0], 1'b0};
            WaveSine:   sample_d = sine_sample;
            WaveRsaw:   sample_d = ~phase_q;
            WaveNoise:  sample_d = lfsr_q[7:0];
            WaveRsvd6:  sample_d = MidScale;
            WaveRsvd7:  sample_d = MidScale;
        endcase
    end

    // All state advances only while enabled; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            phase_q  <= '0;
            lfsr_q   <= LfsrSeed;
            sample_q <= '0;
        end else if (ena) begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            lfsr_q   <= lfsr_d;
            sample_q <= sample_d;
        end
    end

    // Outputs: registered sample, live phase, pads always driven.
    always_comb begin
        uo_out  = sample_q;
        uio_out = phase_q;
        uio_oe  = 8'hFF;
    end

endmodule

// File: tb/tb_tt_um_waves.sv
// Self-checking bench for tt_um_waves against a behavioural model.
module tb_tt_um_waves;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    // Model state
    int          m_cnt;
    int          m_p;
    int          m_last_p;
    int          m_uo;
    logic [15:0] m_lfsr;

    tt_um_waves dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    function automatic int sine_ref(input int p);
        int i, quad, k, q;
        i    = p % 64;
        quad = p / 64;
        k    = (quad % 2 == 1) ? 63 - i : i;
        q    = $rtoi(127.0 * $sin(2.0 * 3.14159265358979 * (real'(k) + 0.5) / 256.0) + 0.5);
        return (quad < 2) ? 128 + q : 127 - q;
    endfunction

    function automatic int wave_ref(input int sel, input int p, input logic [15:0] l);
        case (sel)
            0:       return (p >= 128) ? 255 : 0;
            1:       return p;
            2:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
            3:       return sine_ref(p);
            4:       return 255 - p;
            5:       return int'(l[7:0]);
            default: return 128;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_p      = 0;
        m_last_p = -1;
        m_uo     = 0;
        m_lfsr   = 16'hACE1;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        logic fb;
        @(posedge clk);
        m_last_p = -1;
        if (ena) begin
            m_last_p = m_p;
            m_uo     = wave_ref(int'(ui_in[2:0]), m_p, m_lfsr);
            if (m_cnt >= int'(ui_in[7:3])) begin
                m_cnt  = 0;
                m_p    = (m_p + 1) % 256;
                fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
                m_lfsr = (m_lfsr >> 1) | ({15'd0, fb} << 15);
            end else begin
                m_cnt++;
            end
        end
        #1;
        check("uo_out", {8'd0, uo_out}, m_uo[15:0]);
        check("uio_out", {8'd0, uio_out}, m_p[15:0]);
        check("uio_oe", {8'd0, uio_oe}, 16'h00FF);
    endtask

    // Hold reset across a few edges, checking the cleared state, then release between edges.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_uo", {8'd0, uo_out}, 16'h0000);
            check("rst_uio", {8'd0, uio_out}, 16'h0000);
            check("rst_oe", {8'd0, uio_oe}, 16'h00FF);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] snap_uo, snap_uio;
        int         prev_p;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'($urandom);

        // Square, DIV=0
        do_reset();
        step();
        check("first_count", {8'd0, uio_out}, 16'd1);
        for (int i = 0; i < 600; i++) begin
            step();
            if (m_last_p == 127) check("square_low", {8'd0, uo_out}, 16'h0000);
            if (m_last_p == 128) check("square_rise", {8'd0, uo_out}, 16'h00FF);
        end

        // Sawtooth, DIV=3, through the 255->0 wrap
        ui_in = 8'b00011_001;
        do_reset();
        for (int i = 0; i < 1100; i++) step();

        // DIV lowered below the running count forces a tick on the next edge
        ui_in = {5'd20, 3'b001};
        for (int i = 0; i < 10; i++) step();
        prev_p = int'(uio_out);
        ui_in  = {5'd2, 3'b001};
        step();
        check("div_lower", {8'd0, uio_out}, 16'((prev_p + 1) % 256));

        // Sine, DIV=0
        ui_in = {5'd0, 3'b011};
        do_reset();
        for (int i = 0; i < 260; i++) begin
            step();
            if (m_last_p == 0)   check("sine_p0", {8'd0, uo_out}, 16'd130);
            if (m_last_p == 64)  check("sine_p64", {8'd0, uo_out}, 16'd255);
            if (m_last_p == 128) check("sine_p128", {8'd0, uo_out}, 16'd125);
            if (m_last_p == 192) check("sine_p192", {8'd0, uo_out}, 16'd0);
        end

        // Triangle, DIV=0
        ui_in = {5'd0, 3'b010};
        do_reset();
        for (int i = 0; i < 260; i++) begin
            step();
            if (m_last_p == 127) check("tri_p127", {8'd0, uo_out}, 16'd254);
            if (m_last_p == 128) check("tri_p128", {8'd0, uo_out}, 16'd255);
            if (m_last_p == 255) check("tri_p255", {8'd0, uo_out}, 16'd1);
        end

        // Noise: seed low byte first, then freeze, then async reset mid-run
        ui_in = {5'd0, 3'b101};
        do_reset();
        step();
        check("noise_first", {8'd0, uo_out}, 16'h00E1);
        for (int i = 0; i < 50; i++) step();
        ena      = 1'b0;
        snap_uo  = uo_out;
        snap_uio = uio_out;
        for (int i = 0; i < 20; i++) begin
            ui_in = {5'($urandom_range(0, 31)), 3'b101};
            step();
            check("freeze_uo", {8'd0, uo_out}, {8'd0, snap_uo});
            check("freeze_uio", {8'd0, uio_out}, {8'd0, snap_uio});
        end
        ena   = 1'b1;
        ui_in = {5'd1, 3'b101};
        for (int i = 0; i < 30; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_uo", {8'd0, uo_out}, 16'h0000);
        check("async_rst_uio", {8'd0, uio_out}, 16'h0000);
        do_reset();

        // Randomized: select, DIV, enable and occasional mid-cycle reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                ui_in  = 8'($urandom);
                ena    = ($urandom_range(0, 7) != 0);
                uio_in = 8'($urandom);
            end
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check("rand_rst_uo", {8'd0, uo_out}, 16'h0000);
                check("rand_rst_uio", {8'd0, uio_out}, 16'h0000);
                rst_n = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
